// File: rtl/mlp_run_sequencer.sv
// mlp_run_sequencer: host-side start/done/accuracy initiator for the MLP.
// On go, runs NUM_RUNS passes (MLP reset, start until done, capture accuracy)
// and reports last/best/total accuracy plus sticky status flags.
// Optional feature macro: MLP_RUN_TIMEOUT_EN (per-pass timeout counter + ABORT).
module mlp_run_sequencer #(
  parameter int ACC_WIDTH            = 10,
  parameter int NUMBER_OF_TEST_CASES = 750,
  parameter int NUM_RUNS             = 4,
  parameter int CLOG2_NUM_RUNS       = 2,
  parameter int RST_CYCLES           = 2,
  parameter int TIMEOUT_CYCLES       = 20000,
  parameter int CLOG2_TIMEOUT        = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                go,
  output logic                                busy,
  output logic                                finished,
  output logic                                error_timeout,
  output logic                                error_range,
  output logic [CLOG2_NUM_RUNS-1:0]           run_index,
  output logic [ACC_WIDTH-1:0]                last_accuracy,
  output logic [ACC_WIDTH-1:0]                best_accuracy,
  output logic [ACC_WIDTH+CLOG2_NUM_RUNS-1:0] total_correct,
  output logic                                mlp_rst,
  output logic                                mlp_start,
  input  logic                                mlp_done,
  input  logic [ACC_WIDTH-1:0]                mlp_accuracy
);

  localparam int TW  = ACC_WIDTH + CLOG2_NUM_RUNS;
  localparam int RCW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_CAPTURE, S_ABORT, S_FIN
  } state_t;

  state_t               state, state_nxt;
  logic [RCW-1:0]       rcnt;
  logic                 rst_hold;
  logic                 timeout_hit;
  logic                 last_pass;
  logic                 accept;
  logic [ACC_WIDTH-1:0] acc_p0;

  assign accept    = (state == S_IDLE) && go;
  assign last_pass = (int'(run_index) + 1) >= NUM_RUNS;

`ifdef MLP_RUN_TIMEOUT_EN
  logic [CLOG2_TIMEOUT-1:0] tcnt;

  // Per-pass RUN cycle counter; held at zero outside RUN so it restarts on entry.
  always_ff @(posedge clk) begin
    if (!rst || state != S_RUN) tcnt <= '0;
    else                        tcnt <= tcnt + 1'b1;
  end

  assign timeout_hit = (state == S_RUN) &&
                       (tcnt == CLOG2_TIMEOUT'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag, cleared only by reset or an accepted go.
  always_ff @(posedge clk) begin
    if (!rst)                 error_timeout <= 1'b0;
    else if (accept)          error_timeout <= 1'b0;
    else if (state == S_ABORT) error_timeout <= 1'b1;
  end
`else
  localparam int unused_timeout_cfg = TIMEOUT_CYCLES + CLOG2_TIMEOUT;
  assign timeout_hit   = 1'b0;
  assign error_timeout = 1'b0;
`endif

  // State register; rst_hold keeps mlp_rst high for the cycle after a reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      rst_hold <= 1'b1;
    end else begin
      state    <= state_nxt;
      rst_hold <= 1'b0;
    end
  end

  // MLP reset burst length counter, active only while in CLR.
  always_ff @(posedge clk) begin
    if (!rst || state != S_CLR) rcnt <= '0;
    else                        rcnt <= rcnt + 1'b1;
  end

  // Next-state and Moore outputs; done takes priority over timeout in RUN.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    mlp_rst   = rst_hold || (state == S_CLR) || (state == S_ABORT);
    mlp_start = (state == S_RUN);
    unique case (state)
      S_IDLE:    if (go) state_nxt = S_CLR;
      S_CLR:     if (rcnt == RCW'(RST_CYCLES - 1)) state_nxt = S_RUN;
      S_RUN: begin
        if (mlp_done)         state_nxt = S_CAPTURE;
        else if (timeout_hit) state_nxt = S_ABORT;
      end
      S_CAPTURE: state_nxt = last_pass ? S_FIN : S_CLR;
      S_ABORT:   state_nxt = S_FIN;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: register the accuracy on the cycle RUN sees done.
  always_ff @(posedge clk) begin
    if (state == S_RUN && mlp_done) acc_p0 <= mlp_accuracy;
  end

  // Capture stage: update reported results and sticky status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      finished      <= 1'b0;
      error_range   <= 1'b0;
      run_index     <= '0;
      last_accuracy <= '0;
      best_accuracy <= '0;
      total_correct <= '0;
    end else begin
      if (accept) begin
        finished      <= 1'b0;
        error_range   <= 1'b0;
        run_index     <= '0;
        last_accuracy <= '0;
        best_accuracy <= '0;
        total_correct <= '0;
      end
      if (state == S_CAPTURE) begin
        last_accuracy <= acc_p0;
        total_correct <= total_correct + TW'(acc_p0);
        if (acc_p0 > best_accuracy) best_accuracy <= acc_p0;
        run_index     <= run_index + 1'b1;
        if (acc_p0 > ACC_WIDTH'(NUMBER_OF_TEST_CASES)) error_range <= 1'b1;
      end
      if (state_nxt == S_FIN) finished <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mlp_run_sequencer.sv
// Testbench for mlp_run_sequencer: behavioural MLP responder, reference
// results computed from per-pass accuracy tables, immediate-assertion checks.
module tb_mlp_run_sequencer;

  localparam int ACC_WIDTH = 10;
  localparam int NTC       = 750;
  localparam int NUM_RUNS  = 4;
  localparam int CLOG2_NR  = 2;
  localparam int RST_CYC   = 2;
  localparam int TO_CYC    = 100;
  localparam int CLOG2_TO  = 15;
  localparam int NEVER     = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic go  = 1'b0;
  logic busy, finished, error_timeout, error_range;
  logic [CLOG2_NR-1:0]           run_index;
  logic [ACC_WIDTH-1:0]          last_accuracy, best_accuracy;
  logic [ACC_WIDTH+CLOG2_NR-1:0] total_correct;
  logic mlp_rst, mlp_start;
  logic mlp_done = 1'b0;
  logic [ACC_WIDTH-1:0] mlp_accuracy = '0;

  int total = 0;
  int bad   = 0;

  mlp_run_sequencer #(
    .ACC_WIDTH(ACC_WIDTH), .NUMBER_OF_TEST_CASES(NTC), .NUM_RUNS(NUM_RUNS),
    .CLOG2_NUM_RUNS(CLOG2_NR), .RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TO_CYC),
    .CLOG2_TIMEOUT(CLOG2_TO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .finished(finished),
    .error_timeout(error_timeout), .error_range(error_range),
    .run_index(run_index), .last_accuracy(last_accuracy),
    .best_accuracy(best_accuracy), .total_correct(total_correct),
    .mlp_rst(mlp_rst), .mlp_start(mlp_start), .mlp_done(mlp_done),
    .mlp_accuracy(mlp_accuracy)
  );

  always #5 clk = ~clk;

  // Behavioural MLP: per pass, done rises after lat_tab start cycles.
  int acc_tab [8];
  int lat_tab [8];
  int mpass = 0;
  int mcnt  = 0;

  always @(posedge clk) begin
    if (mlp_rst === 1'b1) begin
      mlp_done <= 1'b0;
      mcnt     <= 0;
    end else if (mlp_start === 1'b1 && !mlp_done) begin
      if (mcnt >= lat_tab[mpass]) begin
        mlp_done     <= 1'b1;
        mlp_accuracy <= acc_tab[mpass][ACC_WIDTH-1:0];
        mpass        <= (mpass < 7) ? mpass + 1 : mpass;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  // Interface monitor: reset bursts, RUN lengths, start drop after done.
  int bursts = 0, burst_len = 0, odd_bursts = 0;
  int start_len = 0, last_start_len = 0, late_start = 0;
  logic prev_rst = 1'b0, prev_start = 1'b0, prev_done_run = 1'b0;

  always @(posedge clk) begin
    #2;
    if (mlp_rst === 1'b1) begin
      if (prev_rst !== 1'b1) begin bursts++; burst_len = 1; end
      else burst_len++;
    end else if (prev_rst === 1'b1 && burst_len != RST_CYC) begin
      odd_bursts++;
    end
    if (mlp_start === 1'b1) start_len++;
    else if (prev_start === 1'b1) begin last_start_len = start_len; start_len = 0; end
    if (prev_done_run && mlp_start === 1'b1) late_start++;
    prev_done_run = (mlp_done === 1'b1) && (mlp_start === 1'b1);
    prev_rst   = mlp_rst;
    prev_start = mlp_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bursts = 0; odd_bursts = 0; late_start = 0; last_start_len = 0;
    mpass = 0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    int n = 0;
    while (finished !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".fin_in_time"}, finished, 1);
  endtask

  // Reference results: derived from the accuracies of the completed passes.
  task automatic check_seq(input string tag, input int n, input bit exp_to);
    int sum = 0, mx = 0, lst = 0;
    bit rng = 1'b0;
    for (int i = 0; i < n; i++) begin
      sum += acc_tab[i];
      if (acc_tab[i] > mx) mx = acc_tab[i];
      lst = acc_tab[i];
      if (acc_tab[i] > NTC) rng = 1'b1;
    end
    check({tag, ".total"},  total_correct, sum);
    check({tag, ".best"},   best_accuracy, mx);
    check({tag, ".last"},   last_accuracy, lst);
    check({tag, ".index"},  run_index, n % NUM_RUNS);
    check({tag, ".erange"}, error_range, rng);
    check({tag, ".etime"},  error_timeout, exp_to);
    check({tag, ".late"},   late_start, 0);
    @(negedge clk);
    check({tag, ".busy_fall"}, busy, 0);
    check({tag, ".fin_sticky"}, finished, 1);
  endtask

  task automatic rand_tabs();
    for (int i = 0; i < 8; i++) begin
      acc_tab[i] = $urandom_range(0, 1023);
      lat_tab[i] = $urandom_range(0, 15);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin acc_tab[i] = 0; lat_tab[i] = 0; end

    // Reset held low for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.finished", finished, 0);
    check("rst.total", total_correct, 0);
    check("rst.flags", {error_timeout, error_range}, 0);
    check("rst.outs", {run_index, last_accuracy, best_accuracy, mlp_start}, 0);
    check("rst.mlp_rst", mlp_rst, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst.mlp_rst_drop", mlp_rst, 0);
    check("rst.idle", busy, 0);

    // Directed 4-pass run with go held and re-pulsed while busy.
    acc_tab[0] = 700; acc_tab[1] = 650; acc_tab[2] = 720; acc_tab[3] = 690;
    lat_tab[0] = 10;  lat_tab[1] = 3;   lat_tab[2] = 0;   lat_tab[3] = 7;
    clear_mon();
    go = 1'b1;
    @(negedge clk);
    check("go.busy", busy, 1);
    for (int i = 0; i < RST_CYC; i++) begin
      if (i > 0) @(negedge clk);
      check("go.clr_rst", {mlp_rst, mlp_start}, 2'b10);
    end
    @(negedge clk);
    check("go.run_start", {mlp_rst, mlp_start}, 2'b01);
    repeat (3) @(negedge clk);
    go = 1'b0;
    n = 0;
    while (mlp_rst !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("go.second_clr", mlp_rst, 1);
    pulse_go();
    wait_fin("dir");
    check_seq("dir", 4, 1'b0);
    repeat (4) @(negedge clk);
    check("dir.no_restart", busy, 0);
    check("dir.bursts", bursts, 4);
    check("dir.burst_len", odd_bursts, 0);

    // Out-of-range accuracy on the first pass.
    acc_tab[0] = 800; acc_tab[1] = 100; acc_tab[2] = 200; acc_tab[3] = 300;
    clear_mon();
    pulse_go();
    wait_fin("range");
    check_seq("range", 4, 1'b0);

    // Randomized sequences.
    for (int r = 0; r < 3; r++) begin
      rand_tabs();
      clear_mon();
      pulse_go();
      wait_fin($sformatf("rnd%0d", r));
      check_seq($sformatf("rnd%0d", r), 4, 1'b0);
      check($sformatf("rnd%0d.bursts", r), bursts, 4);
    end

`ifdef MLP_RUN_TIMEOUT_EN
    // Second pass never completes.
    rand_tabs();
    lat_tab[1] = NEVER;
    clear_mon();
    pulse_go();
    wait_fin("tmo");
    check_seq("tmo", 1, 1'b1);
    check("tmo.run_len", last_start_len, TO_CYC);
    check("tmo.abort_burst", odd_bursts, 1);
`endif

    // Reset during RUN of the third pass, then a fresh sequence.
    rand_tabs();
    lat_tab[2] = 12;
    clear_mon();
    pulse_go();
    n = 0;
    while (!(mpass == 2 && mlp_start === 1'b1 && mlp_done === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid.reached_pass3", mlp_start, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid.busy", busy, 0);
    check("mid.outs", {finished, error_timeout, error_range, run_index, mlp_start}, 0);
    check("mid.acc", {last_accuracy, best_accuracy, total_correct}, 0);
    check("mid.mlp_rst", mlp_rst, 1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("mid.no_fin", finished, 0);
    rand_tabs();
    clear_mon();
    pulse_go();
    wait_fin("fresh");
    check_seq("fresh", 4, 1'b0);
    check("fresh.bursts", bursts, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
